// File: rtl/imem_loader.sv
// Streams a byte-wide program into instruction memory and pads it to a whole
// 32-bit word. The CPU is held in reset until the image is complete.
module imem_loader #(
   parameter int MEM_BYTES = 512,
   parameter int ADDR_W    = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_reset,
   output logic              load_done,
   output logic [ADDR_W:0]   byte_count,
   output logic [7:0]        checksum,
   output logic              overflow
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PAD,
      DONE,
      ERR
   } state_t;

   localparam int              LAST_I    = MEM_BYTES - 1;
   localparam logic [ADDR_W:0] LAST_ADDR = LAST_I[ADDR_W:0];
   localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

   state_t          state;
   state_t          state_nxt;
   logic [ADDR_W:0] wp;
   logic            xfer;
   logic            pad_wr;
   logic            restart;
   logic            wrap_hit;

   assign wrap_hit = (wp == LAST_ADDR);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, plus the per-cycle strobes that steer the datapath below.
   always_comb begin
      state_nxt = state;
      xfer      = 1'b0;
      pad_wr    = 1'b0;
      restart   = 1'b0;
      in_ready  = 1'b0;
      load_done = 1'b0;
      cpu_reset = 1'b1;
      case (state)
         IDLE, ERR: begin
            if (start) begin
               restart   = 1'b1;
               state_nxt = LOAD;
            end
         end
         DONE: begin
            load_done = 1'b1;
            cpu_reset = 1'b0;
            if (start) begin
               restart   = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               xfer = 1'b1;
               if (in_last) begin
                  state_nxt = (wp[1:0] == 2'b11) ? DONE : PAD;
               end else if (wrap_hit) begin
                  state_nxt = ERR;
               end
            end
         end
         PAD: begin
            pad_wr = 1'b1;
            if (wp[1:0] == 2'b11) begin
               state_nxt = DONE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Write port is registered, so each accepted byte lands one cycle later.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wp         <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         byte_count <= '0;
         checksum   <= '0;
         overflow   <= 1'b0;
      end else begin
         mem_we <= xfer | pad_wr;
         if (xfer || pad_wr) begin
            mem_addr  <= wp[ADDR_W-1:0];
            mem_wdata <= xfer ? in_data : 8'h00;
            wp        <= wp + ONE;
         end
         if (xfer) begin
            byte_count <= byte_count + ONE;
            checksum   <= checksum ^ in_data;
         end
         if (xfer && !in_last && wrap_hit) begin
            overflow <= 1'b1;
         end
         if (restart) begin
            wp         <= '0;
            byte_count <= '0;
            checksum   <= '0;
            overflow   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a byte-stream reference model checked every cycle,
// plus directed loads with hand-computed results.
module tb_imem_loader;

   localparam int MEM_BYTES = 512;
   localparam int ADDR_W    = 9;

   logic              clk;
   logic              reset;
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_last;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              cpu_reset;
   logic              load_done;
   logic [ADDR_W:0]   byte_count;
   logic [7:0]        checksum;
   logic              overflow;

   imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_reset  (cpu_reset),
      .load_done  (load_done),
      .byte_count (byte_count),
      .checksum   (checksum),
      .overflow   (overflow)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: accepting bytes, owed pad writes, finished, errored.
   bit          model_valid = 0;
   bit          m_acc;
   int          m_pads;
   bit          m_done;
   int          m_wp;
   int          m_count;
   logic [7:0]  m_sum;
   bit          m_ovf;
   bit          m_we;
   int          m_addr;
   logic [7:0]  m_wdata;

   logic [16:0] wlog[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit st, input bit v, input logic [7:0] d, input bit l, input bit rn);
      @(negedge clk);
      start    = st;
      in_valid = v;
      in_data  = d;
      in_last  = l;
      reset    = rn;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic sendProgram(input logic [7:0] prog[$], input int gap, input bit with_last);
      for (int i = 0; i < prog.size(); i++) begin
         applyStimulus(1'b0, 1'b1, prog[i], with_last && (i == prog.size() - 1), 1'b1);
         if (i != prog.size() - 1) idle(gap);
      end
   endtask

   task automatic waitDone(input int budget, output int cycles);
      cycles = 0;
      while (!load_done && cycles < budget) begin
         idle(1);
         cycles++;
      end
      checkOutput("done_timeout", {31'd0, load_done}, 32'd1);
   endtask

   task automatic modelStep();
      if (!reset) begin
         m_acc = 0; m_pads = 0; m_done = 0; m_wp = 0; m_count = 0;
         m_sum = 8'h00; m_ovf = 0; m_we = 0; m_addr = 0; m_wdata = 8'h00;
         model_valid = 1;
         return;
      end
      m_we = 0;
      if (start && !m_acc && m_pads == 0) begin
         m_acc = 1; m_done = 0; m_wp = 0; m_count = 0; m_sum = 8'h00; m_ovf = 0;
      end else if (m_acc && in_valid) begin
         m_we = 1; m_addr = m_wp % MEM_BYTES; m_wdata = in_data;
         m_wp++; m_count++; m_sum ^= in_data;
         if (in_last) begin
            m_acc  = 0;
            m_pads = (4 - (m_wp % 4)) % 4;
            if (m_pads == 0) m_done = 1;
         end else if (m_wp == MEM_BYTES) begin
            m_acc = 0; m_ovf = 1;
         end
      end else if (m_pads > 0) begin
         m_we = 1; m_addr = m_wp % MEM_BYTES; m_wdata = 8'h00;
         m_wp++; m_pads--;
         if (m_pads == 0) m_done = 1;
      end
   endtask

   // Model advances on the same edge as the DUT; outputs are compared shortly after.
   always @(posedge clk) begin
      modelStep();
      #2;
      if (model_valid) begin
         checkOutput("in_ready",   {31'd0, in_ready},  {31'd0, m_acc});
         checkOutput("mem_we",     {31'd0, mem_we},    {31'd0, m_we});
         checkOutput("mem_addr",   32'(mem_addr),      32'(m_addr));
         checkOutput("mem_wdata",  32'(mem_wdata),     32'(m_wdata));
         checkOutput("cpu_reset",  {31'd0, cpu_reset}, {31'd0, !m_done});
         checkOutput("load_done",  {31'd0, load_done}, {31'd0, m_done});
         checkOutput("byte_count", 32'(byte_count),    32'(m_count));
         checkOutput("checksum",   32'(checksum),      32'(m_sum));
         checkOutput("overflow",   {31'd0, overflow},  {31'd0, m_ovf});
      end
      if (mem_we === 1'b1) wlog.push_back({mem_addr, mem_wdata});
   end

   initial begin
      logic [7:0] prog[$];
      int         cyc;
      int         len;

      start = 0; in_valid = 0; in_data = 8'h00; in_last = 0; reset = 0;
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      idle(2);
      checkOutput("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd0);

      // Word-aligned program: no padding, done right after the last byte.
      prog = '{8'h24, 8'h01, 8'h00, 8'h05, 8'h24, 8'h02, 8'h00, 8'h03};
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      wlog.delete();
      sendProgram(prog, 0, 1'b1);
      waitDone(20, cyc);
      checkOutput("aligned_latency", 32'(cyc), 32'd1);
      checkOutput("aligned_count",   32'(byte_count), 32'd8);
      checkOutput("aligned_sum",     32'(checksum), 32'h05);
      checkOutput("aligned_cpu_rst", {31'd0, cpu_reset}, 32'd0);
      checkOutput("aligned_nwr",     32'(wlog.size()), 32'd8);
      for (int i = 0; i < 8 && i < wlog.size(); i++)
         checkOutput("aligned_wr", 32'(wlog[i]), 32'({i[8:0], prog[i]}));

      // Restart from DONE.
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      idle(1);
      checkOutput("restart_cpu_rst", {31'd0, cpu_reset}, 32'd1);
      checkOutput("restart_done",    {31'd0, load_done}, 32'd0);
      checkOutput("restart_count",   32'(byte_count), 32'd0);
      checkOutput("restart_ready",   {31'd0, in_ready}, 32'd1);

      // Five bytes: three pad writes follow.
      prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      wlog.delete();
      sendProgram(prog, 0, 1'b1);
      waitDone(20, cyc);
      checkOutput("pad_latency", 32'(cyc), 32'd4);
      checkOutput("pad_count",   32'(byte_count), 32'd5);
      checkOutput("pad_sum",     32'(checksum), 32'hEE);
      checkOutput("pad_nwr",     32'(wlog.size()), 32'd8);
      if (wlog.size() == 8) begin
         checkOutput("pad_wr5", 32'(wlog[5]), 32'({9'd5, 8'h00}));
         checkOutput("pad_wr6", 32'(wlog[6]), 32'({9'd6, 8'h00}));
         checkOutput("pad_wr7", 32'(wlog[7]), 32'({9'd7, 8'h00}));
      end

      // Gapped transfers stay contiguous.
      prog = '{8'h11, 8'h22, 8'h33, 8'h44};
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      wlog.delete();
      sendProgram(prog, 2, 1'b1);
      waitDone(20, cyc);
      checkOutput("gap_nwr",  32'(wlog.size()), 32'd4);
      if (wlog.size() == 4)
         checkOutput("gap_last", 32'(wlog[3]), 32'({9'd3, 8'h44}));

      // Fill memory without in_last.
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      wlog.delete();
      for (int i = 0; i < MEM_BYTES; i++)
         applyStimulus(1'b0, 1'b1, 8'(i * 7), 1'b0, 1'b1);
      idle(3);
      checkOutput("ovf_flag",  {31'd0, overflow},  32'd1);
      checkOutput("ovf_ready", {31'd0, in_ready},  32'd0);
      checkOutput("ovf_cpu",   {31'd0, cpu_reset}, 32'd1);
      checkOutput("ovf_count", 32'(byte_count), 32'd512);
      checkOutput("ovf_nwr",   32'(wlog.size()), 32'd512);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      idle(1);
      checkOutput("ovf_clear", {31'd0, overflow}, 32'd0);

      // Reset after the third accepted byte.
      prog = '{8'h01, 8'h02, 8'h03};
      sendProgram(prog, 0, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h04, 1'b0, 1'b0);
      wlog.delete();
      applyStimulus(1'b0, 1'b1, 8'h05, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 8'h06, 1'b0, 1'b1);
      idle(1);
      checkOutput("midrst_count", 32'(byte_count), 32'd0);
      checkOutput("midrst_nwr",   32'(wlog.size()), 32'd0);

      // Randomized loads, gaps, stray starts/in_last and occasional resets.
      for (int t = 0; t < 40; t++) begin
         applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
         len = $urandom_range(1, 24);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0)
               applyStimulus($urandom_range(0, 1) == 1, 1'b0, 8'($urandom), $urandom_range(0, 1) == 1, 1'b1);
            if ($urandom_range(0, 60) == 0)
               applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
            applyStimulus($urandom_range(0, 5) == 0, 1'b1, 8'($urandom), i == len - 1, 1'b1);
         end
         idle($urandom_range(1, 6));
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
